// File: rtl/load_store_unit.sv
// Load/store unit between a pipeline request port and a single-cycle word memory.
// Sub-word stores use read-modify-write; misaligned or illegal-size accesses complete with an error.
module load_store_unit #(
   parameter bit LITTLE_ENDIAN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

   state_t      state;
   logic [31:0] r_addr;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [15:0] r_wdata;

   logic        mem_read_q, mem_write_q, resp_valid_q, resp_err_q;
   logic [31:0] mem_addr_q, mem_wdata_q, resp_rdata_q;

   function automatic logic is_error(input logic [1:0] size, input logic [1:0] a);
      return (size == 2'b11) || (size == SZ_HALF && a[0]) || (size == SZ_WORD && a != 2'b00);
   endfunction

   // Bit offset of the addressed lane inside the memory word.
   function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] a);
      logic [4:0] sh;
      sh = 5'd0;
      if (size == SZ_BYTE)
         sh = LITTLE_ENDIAN ? {a, 3'b000} : {~a, 3'b000};
      else if (size == SZ_HALF)
         sh = LITTLE_ENDIAN ? {a[1], 4'b0000} : {~a[1], 4'b0000};
      return sh;
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] a, input logic uns);
      logic [31:0] w;
      w = word >> lane_shift(size, a);
      case (size)
         SZ_BYTE: return uns ? {24'b0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
         SZ_HALF: return uns ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [15:0] wd,
                                         input logic [1:0] size, input logic [1:0] a);
      logic [31:0] mask;
      logic [4:0]  sh;
      sh   = lane_shift(size, a);
      mask = ((size == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
      return (old & ~mask) | ((32'(wd) << sh) & mask);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         r_addr       <= '0;
         r_size       <= '0;
         r_unsigned   <= 1'b0;
         r_wdata      <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         // Every registered output is a one-cycle strobe unless a state sets it below.
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         case (state)
            IDLE: if (req_valid) begin
               r_addr     <= req_addr;
               r_size     <= req_size;
               r_unsigned <= req_unsigned;
               r_wdata    <= req_wdata[15:0];
               if (is_error(req_size, req_addr[1:0])) begin
                  state        <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
               end else if (!req_write) begin
                  state      <= LOAD;
                  mem_read_q <= 1'b1;
                  mem_addr_q <= {req_addr[31:2], 2'b00};
               end else if (req_size == SZ_WORD) begin
                  state       <= WRITE;
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= {req_addr[31:2], 2'b00};
                  mem_wdata_q <= req_wdata;
               end else begin
                  state      <= RMW_RD;
                  mem_read_q <= 1'b1;
                  mem_addr_q <= {req_addr[31:2], 2'b00};
               end
            end
            LOAD: begin
               state        <= RESP;
               resp_valid_q <= 1'b1;
               resp_rdata_q <= extract(mem_rdata, r_size, r_addr[1:0], r_unsigned);
            end
            RMW_RD: begin
               state       <= WRITE;
               mem_write_q <= 1'b1;
               mem_addr_q  <= {r_addr[31:2], 2'b00};
               mem_wdata_q <= merge(mem_rdata, r_wdata, r_size, r_addr[1:0]);
            end
            WRITE: begin
               state        <= RESP;
               resp_valid_q <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: outputs are masked by reset so a reset raised mid-WRITE suppresses the memory commit.
   assign req_ready  = (state == IDLE) && !reset;
   assign mem_read   = mem_read_q & ~reset;
   assign mem_write  = mem_write_q & ~reset;
   assign mem_addr   = reset ? 32'b0 : mem_addr_q;
   assign mem_wdata  = reset ? 32'b0 : mem_wdata_q;
   assign resp_valid = resp_valid_q & ~reset;
   assign resp_err   = resp_err_q & ~reset;
   assign resp_rdata = reset ? 32'b0 : resp_rdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter LITTLE_ENDIAN, default 1: 1 = byte 0 at bits [7:0], 0 = byte 0 at bits [31:24].
REQ-002 SHALL have port clk  in  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  in  1  pipeline presents an access.
REQ-005 SHALL have port req_ready  out  1  unit accepts a request this cycle.
REQ-006 SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have port req_addr  in  32  byte address.
REQ-010 SHALL have port req_wdata  in  32  store data, right-justified.
REQ-011 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  out  1  valid with resp_valid; misaligned or illegal size.
REQ-014 SHALL have port mem_read  out  1  word-memory read enable; mem_rdata combinational same cycle.
REQ-015 SHALL have port mem_write  out  1  word-memory write enable; committed at clock edge.
REQ-016 SHALL have port mem_addr  out  32  word-aligned address {req_addr[31:2],2'b00}.
REQ-017 SHALL have port mem_wdata  out  32  full word to write.
REQ-018 SHALL have port mem_rdata  in  32  word returned by memory.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, RMW_RD, WRITE, RESP.
REQ-020 SHALL assert req_ready only in IDLE; handshake = req_valid && req_ready; all req_* fields latched at that edge.
REQ-021 On accept, next state: error -> RESP; load -> LOAD; word store -> WRITE; byte/half store -> RMW_RD.
REQ-022 Error SHALL be: size 11, size 01 with addr[0]=1, or size 10 with addr[1:0]!=0; no memory access on error.
REQ-023 LOAD: mem_read=1 one cycle; selected byte/half extracted per addr[1:0] and LITTLE_ENDIAN, extended per req_unsigned, registered; -> RESP.
REQ-024 RMW_RD: mem_read=1 one cycle; full mem_rdata word registered; -> WRITE.
REQ-025 WRITE: mem_write=1 one cycle; mem_wdata = req_wdata (word) or registered word with target byte/half lanes replaced by req_wdata[7:0]/[15:0]; -> RESP.
REQ-026 RESP: resp_valid=1 exactly one cycle, no backpressure; -> IDLE.
REQ-027 Latency accept-to-resp_valid SHALL be: error 1 cycle, load 2, word store 2, sub-word store 3.
REQ-028 mem_read and mem_write SHALL never be high together; both 0 in IDLE and RESP.
REQ-029 mem_addr and mem_wdata SHALL be 0 when neither mem_read nor mem_write is high.
REQ-030 resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.
REQ-031 Back-to-back: a request held through RESP SHALL be accepted in the following IDLE cycle (min 1 idle cycle between requests).

Reset
REQ-032 reset=1 at a rising edge SHALL force IDLE and clear all registers, taking priority over every transition.
REQ-033 During reset and the cycle after, outputs SHALL be: req_ready=1 (after release), resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-034 Reset asserted in RMW_RD or WRITE SHALL abort the access: no mem_write issued, no resp_valid, pending request discarded.

Verification
REQ-035 Word store addr 0x10 data 0xDEADBEEF -> WRITE cycle mem_addr=0x10, mem_wdata=0xDEADBEEF; resp_valid 2 cycles after accept, resp_err=0.
REQ-036 Memory word 0x80FF7F01 at 0x20; lb addr 0x22 signed -> resp_rdata=0xFFFFFFFF; lbu addr 0x23 -> 0x00000080; lh addr 0x20 -> 0x00007F01 (LITTLE_ENDIAN=1).
REQ-037 Word 0x11223344 at 0x30; sb addr 0x31 data 0xAA -> RMW_RD then mem_wdata=0x1122AA44; resp 3 cycles after accept.
REQ-038 lw addr 0x42 and lh addr 0x43 -> resp_err=1 1 cycle after accept, mem_read/mem_write never asserted.
REQ-039 Assert reset during WRITE of sh 0x50 -> mem_write stays 0, no resp_valid, req_ready=1 the cycle after reset releases.
